// File: rtl/tm_multislave_pkg.sv
// Shared types and helpers for the multislave traffic manager.
// The table entry is sized for the widest supported configuration; unused upper bits stay zero.
package tm_multislave_pkg;

  localparam int MAX_VCS   = 16;
  localparam int KEY_MAX_W = 16;
  localparam int CNT_MAX_W = 16;

  typedef struct packed {
    logic                 bound;
    logic [KEY_MAX_W-1:0] key;
    logic [CNT_MAX_W-1:0] count;
  } ret_vc_entry_t;

  function automatic int cnt_width(input int n);
    return $clog2(n + 1);
  endfunction

  // Index of the lowest set request bit; 0 when nothing is set.
  function automatic logic [3:0] lowest_index(input logic [MAX_VCS-1:0] req);
    lowest_index = '0;
    for (int i = MAX_VCS - 1; i >= 0; i--) begin
      if (req[i]) lowest_index = 4'(i);
    end
  endfunction

endpackage

// File: rtl/tm_order_fifo.sv
// Show-ahead FIFO recording the return VC of each issued request, in issue order.
// The head reads as zero while empty so the exposed next-VC output is clean after reset.
module tm_order_fifo #(
  parameter int WIDTH = 2,
  parameter int DEPTH = 32
) (
  input  logic                     clk,
  input  logic                     clear,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr, rd_ptr;
  logic             full, do_push, do_pop;

  assign count   = wr_ptr - rd_ptr;
  assign empty   = (count == '0);
  assign full    = (count == (AW + 1)'(DEPTH));
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = empty ? '0 : mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (AW + 1)'(1);
      if (do_pop)  rd_ptr <= rd_ptr + (AW + 1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/tm_master_multislave_vc.sv
// Credit-based NoC master traffic manager binding slave streams to return VCs.
// Define TM_MULTISLAVE_CHECK_EN for simulation-only protocol checks.
module tm_master_multislave_vc
  import tm_multislave_pkg::*;
#(
  parameter int NUM_CREDITS      = 32,
  parameter int ADDRESS_WIDTH    = 4,
  parameter int VC_ADDRESS_WIDTH = 2,
  parameter int WIDTH_DATA       = 36,
  parameter int NUM_RET_VCS      = 4,
  parameter int ORDER_DEPTH      = 32
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        send_valid_in,
  output logic                        send_ready_out,
  input  logic [WIDTH_DATA-1:0]       send_data_in,
  input  logic [ADDRESS_WIDTH-1:0]    send_dest_in,
  input  logic [VC_ADDRESS_WIDTH-1:0] send_vc_in,
  output logic                        send_valid_out,
  output logic [WIDTH_DATA-1:0]       send_data_out,
  output logic [ADDRESS_WIDTH-1:0]    send_dest_out,
  output logic [VC_ADDRESS_WIDTH-1:0] send_vc_out,
  output logic [VC_ADDRESS_WIDTH-1:0] send_ret_vc,
  input  logic                        send_ready_in,
  input  logic [NUM_RET_VCS-1:0]      receive_valid,
  output logic [VC_ADDRESS_WIDTH-1:0] curr_ret_vc,
  output logic                        curr_ret_vc_valid
);

  localparam int ENTRY_W = WIDTH_DATA + ADDRESS_WIDTH + VC_ADDRESS_WIDTH;
  localparam int KEY_W   = VC_ADDRESS_WIDTH + ADDRESS_WIDTH;
  localparam int OCC_W   = $clog2(ORDER_DEPTH) + 1;

  logic [ENTRY_W-1:0]          in_entry, head_p0, tail_p0;
  logic                        vld_head_p0, vld_tail_p0, rdy_p0, push;
  logic [WIDTH_DATA-1:0]       head_data;
  logic [ADDRESS_WIDTH-1:0]    head_dest;
  logic [VC_ADDRESS_WIDTH-1:0] head_vc, sel, ord_head;
  logic [KEY_W-1:0]            head_key;
  ret_vc_entry_t               tbl [NUM_RET_VCS];
  ret_vc_entry_t               tbl_nxt [NUM_RET_VCS];
  logic [MAX_VCS-1:0]          match_req, free_req;
  logic [3:0]                  pick_m, pick_f;
  logic                        has_vc, credit_ok, issue, ord_empty, ord_full;
  logic [OCC_W-1:0]            ord_count;

  // ---- stage p0: two-entry skid buffer, stored as {payload, dest, vc} ----
  assign in_entry       = {send_data_in, send_dest_in, send_vc_in};
  assign push           = send_valid_in && rdy_p0;
  assign send_ready_out = rdy_p0;
  assign head_vc        = head_p0[VC_ADDRESS_WIDTH-1:0];
  assign head_dest      = head_p0[VC_ADDRESS_WIDTH +: ADDRESS_WIDTH];
  assign head_data      = head_p0[ENTRY_W-1 -: WIDTH_DATA];
  assign head_key       = {head_vc, head_dest};

  // push only happens with the tail empty, so a pop never has to shuffle three entries
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_head_p0 <= 1'b0;
      vld_tail_p0 <= 1'b0;
      rdy_p0      <= 1'b1;
    end else if (issue) begin
      vld_head_p0 <= push || vld_tail_p0;
      vld_tail_p0 <= 1'b0;
      rdy_p0      <= 1'b1;
    end else if (push) begin
      vld_head_p0 <= 1'b1;
      vld_tail_p0 <= vld_head_p0;
      rdy_p0      <= !vld_head_p0;
    end
  end

  always_ff @(posedge clk) begin
    if (issue) head_p0 <= push ? in_entry : tail_p0;
    else if (push && !vld_head_p0) head_p0 <= in_entry;
    if (push && vld_head_p0 && !issue) tail_p0 <= in_entry;
  end

  // Return-VC selection: reuse a live binding for this key, else the lowest free VC.
  always_comb begin
    match_req = '0;
    free_req  = '0;
    for (int i = 0; i < NUM_RET_VCS; i++) begin
      match_req[i] = tbl[i].bound && (tbl[i].key == KEY_MAX_W'(head_key));
      free_req[i]  = (tbl[i].count == '0);
    end
  end

  assign pick_m    = lowest_index(match_req);
  assign pick_f    = lowest_index(free_req);
  assign has_vc    = (|match_req) || (|free_req);
  assign sel       = (|match_req) ? VC_ADDRESS_WIDTH'(pick_m) : VC_ADDRESS_WIDTH'(pick_f);
  assign credit_ok = tbl[sel].count < CNT_MAX_W'(NUM_CREDITS);
  assign ord_full  = (ord_count == OCC_W'(ORDER_DEPTH));
  assign issue     = vld_head_p0 && has_vc && credit_ok && send_ready_in && !ord_full;

  always_comb begin
    for (int i = 0; i < NUM_RET_VCS; i++) begin
      tbl_nxt[i]       = tbl[i];
      tbl_nxt[i].count = tbl[i].count
                       + CNT_MAX_W'(issue && (sel == VC_ADDRESS_WIDTH'(i)))
                       - CNT_MAX_W'(receive_valid[i] && (tbl[i].count != '0));
      if (issue && (sel == VC_ADDRESS_WIDTH'(i))) tbl_nxt[i].key = KEY_MAX_W'(head_key);
      tbl_nxt[i].bound = (tbl_nxt[i].count != '0);
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_RET_VCS; i++) begin
      if (rst) tbl[i] <= '0;
      else     tbl[i] <= tbl_nxt[i];
    end
  end

  // ---- stage p1: registered issue towards the packetizer ----
  always_ff @(posedge clk) begin
    if (rst) begin
      send_valid_out <= 1'b0;
      send_data_out  <= '0;
      send_dest_out  <= '0;
      send_vc_out    <= '0;
      send_ret_vc    <= '0;
    end else begin
      send_valid_out <= issue;
      if (issue) begin
        send_data_out <= head_data;
        send_dest_out <= head_dest;
        send_vc_out   <= head_vc;
        send_ret_vc   <= sel;
      end
    end
  end

  tm_order_fifo #(
    .WIDTH (VC_ADDRESS_WIDTH),
    .DEPTH (ORDER_DEPTH)
  ) u_order (
    .clk       (clk),
    .clear     (rst),
    .push      (issue),
    .push_data (sel),
    .pop       (|receive_valid),
    .head      (ord_head),
    .empty     (ord_empty),
    .count     (ord_count)
  );

  assign curr_ret_vc       = ord_head;
  assign curr_ret_vc_valid = !ord_empty;

`ifdef TM_MULTISLAVE_CHECK_EN
  if (NUM_RET_VCS > (1 << VC_ADDRESS_WIDTH) || NUM_RET_VCS > MAX_VCS ||
      KEY_W > KEY_MAX_W || cnt_width(NUM_CREDITS) > CNT_MAX_W) begin : g_cfg_err
    $error("tm_master_multislave_vc: unsupported parameter combination");
  end

  always @(posedge clk) begin
    if (!rst) begin
      if (!$onehot0(receive_valid)) begin
        $error("receive_valid is not one-hot0"); $stop;
      end
      if ((|receive_valid) && !curr_ret_vc_valid) begin
        $error("pop of empty order FIFO"); $stop;
      end
      for (int i = 0; i < NUM_RET_VCS; i++) begin
        if (receive_valid[i] && curr_ret_vc != VC_ADDRESS_WIDTH'(i)) begin
          $error("response on VC %0d while VC %0d is due", i, curr_ret_vc); $stop;
        end
        if (receive_valid[i] && tbl[i].count == '0) begin
          $error("credit underflow on VC %0d", i); $stop;
        end
      end
      if (issue && tbl[sel].count >= CNT_MAX_W'(NUM_CREDITS)) begin
        $error("credit overflow on VC %0d", sel); $stop;
      end
    end
  end
`endif

endmodule
